// File: rtl/level_meter_stereo_scheduler_if.sv
// Stereo level-meter bundle: sample input, shared converter handshake and LED-driver output.
// The scheduler connects through master; the surrounding system connects through slave.
interface level_meter_stereo_scheduler_if;
  logic        i_sample_valid;
  logic [15:0] i_pcm_l;
  logic [15:0] i_pcm_r;
  logic        i_frame_tick;
  logic        conv_valid;
  logic        conv_ready;
  logic [14:0] conv_pcm;
  logic        conv_o_valid;
  logic        conv_o_ready;
  logic [4:0]  conv_position;
  logic        o_valid;
  logic        o_ready;
  logic [4:0]  o_level_l;
  logic [4:0]  o_level_r;
  logic [4:0]  o_peak_l;
  logic [4:0]  o_peak_r;
  logic        o_overrun;

  modport master (
    input  i_sample_valid, i_pcm_l, i_pcm_r, i_frame_tick,
    input  conv_ready, conv_o_valid, conv_position, o_ready,
    output conv_valid, conv_pcm, conv_o_ready,
    output o_valid, o_level_l, o_level_r, o_peak_l, o_peak_r, o_overrun
  );

  modport slave (
    output i_sample_valid, i_pcm_l, i_pcm_r, i_frame_tick,
    output conv_ready, conv_o_valid, conv_position, o_ready,
    input  conv_valid, conv_pcm, conv_o_ready,
    input  o_valid, o_level_l, o_level_r, o_peak_l, o_peak_r, o_overrun
  );
endinterface

// File: rtl/level_meter_stereo_scheduler.sv
// Per-frame stereo peak tracker that time-shares one magnitude-to-position converter
// (left, then right) and applies peak-hold/decay before presenting both bars.
module level_meter_stereo_scheduler #(
  parameter int unsigned HOLD_FRAMES = 16
) (
  input logic clk,
  input logic reset,
  level_meter_stereo_scheduler_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, UPD, OUT} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);

  state_t      state, state_n;
  logic [14:0] mag_l, mag_r, cand_l, cand_r;
  logic [14:0] acc_l, acc_r, pend_l, pend_r, snap_l, snap_r;
  logic        pending, tick_take, tick_drop, overrun;
  logic [4:0]  lev_l, lev_r, level_l, level_r, peak_l, peak_r;
  logic [7:0]  hold_l, hold_r;
  logic [12:0] step_l, step_r;

  function automatic logic [14:0] mag(input logic [15:0] x);
    if (x == 16'h8000) return 15'h7fff;
    else if (x[15])    return 15'((~x) + 16'd1);
    else               return x[14:0];
  endfunction

  // Returns {peak, hold} after one frame of peak-hold/decay.
  function automatic logic [12:0] peak_step(input logic [4:0] lev, input logic [4:0] pk,
                                            input logic [7:0] hd);
    if (lev >= pk)             return {lev, HOLD_INIT};
    else if (hd != 8'd0)       return {pk, hd - 8'd1};
    else if (pk - 5'd1 > lev)  return {pk - 5'd1, hd};
    else                       return {lev, hd};
  endfunction

  always_comb begin
    mag_l     = mag(bus.i_pcm_l);
    mag_r     = mag(bus.i_pcm_r);
    cand_l    = (bus.i_sample_valid && mag_l > acc_l) ? mag_l : acc_l;
    cand_r    = (bus.i_sample_valid && mag_r > acc_r) ? mag_r : acc_r;
    tick_take = bus.i_frame_tick && (state == IDLE || !pending);
    tick_drop = bus.i_frame_tick && !tick_take;
    step_l    = peak_step(lev_l, peak_l, hold_l);
    step_r    = peak_step(lev_r, peak_r, hold_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n          = state;
    bus.conv_valid   = 1'b0;
    bus.conv_pcm     = '0;
    bus.conv_o_ready = 1'b0;
    bus.o_valid      = 1'b0;
    case (state)
      IDLE:   if (pending) state_n = REQ_L;
      REQ_L: begin
        bus.conv_valid = 1'b1;
        bus.conv_pcm   = snap_l;
        if (bus.conv_ready) state_n = WAIT_L;
      end
      WAIT_L: begin
        bus.conv_o_ready = 1'b1;
        if (bus.conv_o_valid) state_n = REQ_R;
      end
      REQ_R: begin
        bus.conv_valid = 1'b1;
        bus.conv_pcm   = snap_r;
        if (bus.conv_ready) state_n = WAIT_R;
      end
      WAIT_R: begin
        bus.conv_o_ready = 1'b1;
        if (bus.conv_o_valid) state_n = UPD;
      end
      UPD:    state_n = OUT;
      OUT: begin
        bus.o_valid = 1'b1;
        if (bus.o_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Accepted ticks always land in pend_*; snap_* is refreshed only from IDLE, so
  // conv_pcm never moves while a conversion sequence is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_l   <= '0;
      acc_r   <= '0;
      pend_l  <= '0;
      pend_r  <= '0;
      snap_l  <= '0;
      snap_r  <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      lev_l   <= '0;
      lev_r   <= '0;
      level_l <= '0;
      level_r <= '0;
      peak_l  <= '0;
      peak_r  <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
    end else begin
      if (bus.i_frame_tick) begin
        acc_l <= '0;
        acc_r <= '0;
      end else if (bus.i_sample_valid) begin
        acc_l <= cand_l;
        acc_r <= cand_r;
      end
      if (tick_take) begin
        pend_l <= cand_l;
        pend_r <= cand_r;
      end
      if (tick_take)          pending <= 1'b1;
      else if (state == IDLE) pending <= 1'b0;
      if (state == IDLE && pending) begin
        snap_l <= pend_l;
        snap_r <= pend_r;
      end
      overrun <= tick_drop;
      if (state == WAIT_L && bus.conv_o_valid) lev_l <= bus.conv_position;
      if (state == WAIT_R && bus.conv_o_valid) lev_r <= bus.conv_position;
      if (state == UPD) begin
        level_l          <= lev_l;
        level_r          <= lev_r;
        {peak_l, hold_l} <= step_l;
        {peak_r, hold_r} <= step_r;
      end
    end
  end

  assign bus.o_level_l = level_l;
  assign bus.o_level_r = level_r;
  assign bus.o_peak_l  = peak_l;
  assign bus.o_peak_r  = peak_r;
  assign bus.o_overrun = overrun;

endmodule
